// File: rtl/mealy_run_detector.sv
// Mealy detector for runs of RUN_LEN identical bits on a qualified serial stream,
// with overlap control, polarity select and a saturating detection counter.
module mealy_run_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             c,
  input  logic             overlap,
  input  logic [1:0]       pol_sel,
  input  logic             clr_cnt,
  output logic             d,
  output logic             d_one,
  output logic             d_zero,
  output logic [CNT_W-1:0] det_cnt,
  output logic             cnt_sat
);

  localparam int RW = (RUN_LEN < 2) ? 1 : $clog2(RUN_LEN);
  localparam logic [RW-1:0]    R_MAX   = RW'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (RUN_LEN < 2) begin : g_bad_run_len
    $error("mealy_run_detector: RUN_LEN must be >= 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic             b_q;
  logic [RW-1:0]    r_q;
  logic [CNT_W-1:0] det_cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_sat_q;
  logic             hit_s;
  logic             pol_en_s;

  // Mealy detect: completes on the current bit when the stored run is one short
  always_comb begin
    hit_s    = en & (state_q == ST_RUN) & (c == b_q) & (r_q == R_MAX);
    pol_en_s = b_q ? pol_sel[0] : pol_sel[1];
    d        = hit_s & pol_en_s;
    d_one    = d & b_q;
    d_zero   = d & ~b_q;
  end

  // Next count: clear beats a detection, and the count never wraps
  always_comb begin
    cnt_d = det_cnt_q;
    if (clr_cnt) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (d && (det_cnt_q != CNT_MAX)) begin
      cnt_d = det_cnt_q + CNT_W'(1);
    end else begin
      cnt_d = det_cnt_q;
    end
  end

  // Run tracker; a full run that is not reported (or overlapping) stays parked at R_MAX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      b_q     <= 1'b0;
      r_q     <= {RW{1'b0}};
    end else if (en) begin
      if (state_q == ST_IDLE) begin
        state_q <= ST_RUN;
        b_q     <= c;
        r_q     <= RW'(1);
      end else if (c != b_q) begin
        b_q <= c;
        r_q <= RW'(1);
      end else if (r_q != R_MAX) begin
        r_q <= r_q + RW'(1);
      end else if (d && !overlap) begin
        state_q <= ST_IDLE;
        r_q     <= {RW{1'b0}};
      end else begin
        r_q <= R_MAX;
      end
    end
  end

  // Detection counter and its saturation flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_cnt_q <= {CNT_W{1'b0}};
      cnt_sat_q <= 1'b0;
    end else begin
      det_cnt_q <= cnt_d;
      cnt_sat_q <= (cnt_d == CNT_MAX);
    end
  end

  assign det_cnt = det_cnt_q;
  assign cnt_sat = cnt_sat_q;

endmodule

// File: tb/tb_mealy_run_detector.sv
// Directed scoreboard bench for mealy_run_detector: three parameterisations share
// one stimulus stream; a reference model predicts d/d_one/d_zero and the counter.
module tb_mealy_run_detector;

  logic       clk = 1'b0;
  logic       reset, en, c, overlap, clr_cnt;
  logic [1:0] pol_sel;

  logic       d_a, do_a, dz_a, sat_a;
  logic [7:0] cnt_a;
  logic       d_b, do_b, dz_b, sat_b;
  logic [1:0] cnt_b;
  logic       d_c, do_c, dz_c, sat_c;
  logic [7:0] cnt_c;

  always #5 clk = ~clk;

  mealy_run_detector #(.RUN_LEN(3), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .en(en), .c(c), .overlap(overlap), .pol_sel(pol_sel),
    .clr_cnt(clr_cnt), .d(d_a), .d_one(do_a), .d_zero(dz_a), .det_cnt(cnt_a), .cnt_sat(sat_a));
  mealy_run_detector #(.RUN_LEN(3), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .en(en), .c(c), .overlap(overlap), .pol_sel(pol_sel),
    .clr_cnt(clr_cnt), .d(d_b), .d_one(do_b), .d_zero(dz_b), .det_cnt(cnt_b), .cnt_sat(sat_b));
  mealy_run_detector #(.RUN_LEN(5), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .en(en), .c(c), .overlap(overlap), .pol_sel(pol_sel),
    .clr_cnt(clr_cnt), .d(d_c), .d_one(do_c), .d_zero(dz_c), .det_cnt(cnt_c), .cnt_sat(sat_c));

  int         sel;
  logic       o_d, o_do, o_dz, o_sat;
  logic [7:0] o_cnt;

  always_comb begin
    case (sel)
      1:       begin o_d = d_b; o_do = do_b; o_dz = dz_b; o_sat = sat_b; o_cnt = {6'd0, cnt_b}; end
      2:       begin o_d = d_c; o_do = do_c; o_dz = dz_c; o_sat = sat_c; o_cnt = cnt_c; end
      default: begin o_d = d_a; o_do = do_a; o_dz = dz_a; o_sat = sat_a; o_cnt = cnt_a; end
    endcase
  end

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int stepn = 0;
  int m_len, m_cnt, rl, cmax;
  bit m_b;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = $sformatf("%s@step%0d", tag, stepn);
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=entry", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  // One bit slot: predict, check Mealy outputs before the edge, counter after it
  task automatic step(input bit cv, input bit ev, input bit clr);
    int nl;
    bit pe, xd;
    stepn++;
    c = cv; en = ev; clr_cnt = clr;
    xd = 1'b0;
    nl = m_len;
    if (ev) begin
      nl = (m_len > 0 && cv == m_b) ? m_len + 1 : 1;
      if (nl == rl) begin
        pe = cv ? pol_sel[0] : pol_sel[1];
        xd = pe;
        nl = (pe && !overlap) ? 0 : rl - 1;
      end
    end
    push("d", 8'(xd));
    push("d_one", 8'(xd & cv));
    push("d_zero", 8'(xd & ~cv));
    @(negedge clk);
    pop_chk({7'd0, o_d});
    pop_chk({7'd0, o_do});
    pop_chk({7'd0, o_dz});
    if (ev) begin
      m_len = nl;
      m_b   = cv;
    end
    if (clr) m_cnt = 0;
    else if (xd && m_cnt < cmax) m_cnt++;
    push("det_cnt", 8'(m_cnt));
    push("cnt_sat", 8'(m_cnt == cmax));
    @(posedge clk);
    #1;
    pop_chk(o_cnt);
    pop_chk({7'd0, o_sat});
  endtask

  task automatic run(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i] == "1", 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic do_reset();
    en = 1'b0; clr_cnt = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_len = 0;
    m_cnt = 0;
    #1;
    check("rst_cnt", o_cnt, 8'd0);
    check("rst_sat", {7'd0, o_sat}, 8'd0);
    check("rst_d", {7'd0, o_d}, 8'd0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; c = 1'b0; overlap = 1'b0; pol_sel = 2'b00; clr_cnt = 1'b0;
    sel = 0; rl = 3; cmax = 255; m_len = 0; m_cnt = 0; m_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Mixed stream, overlapping, either polarity
    do_reset();
    overlap = 1'b1; pol_sel = 2'b11;
    run("1000101110111000");
    check("t1_total", o_cnt, 8'd4);

    // Long run of ones, overlapping versus non-overlapping
    do_reset();
    run("111111");
    check("t2_ovl_total", o_cnt, 8'd4);
    do_reset();
    overlap = 1'b0;
    run("111111");
    check("t2_novl_total", o_cnt, 8'd2);

    // Polarity selection
    do_reset();
    overlap = 1'b1; pol_sel = 2'b01;
    run("0000111");
    check("t3_ones_total", o_cnt, 8'd1);
    do_reset();
    pol_sel = 2'b00;
    run("1111100000");
    check("t3_off_total", o_cnt, 8'd0);

    // Valid gaps keep the run; reset mid-run restarts it
    do_reset();
    pol_sel = 2'b11;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t4_gap_total", o_cnt, 8'd1);
    do_reset();
    run("11");
    do_reset();
    run("1");
    check("t4_rst_nodet", o_cnt, 8'd0);
    run("11");
    check("t4_rst_total", o_cnt, 8'd1);

    // Overlap switched off mid-run takes effect on the current bit
    do_reset();
    overlap = 1'b1;
    run("1111");
    overlap = 1'b0;
    run("1111");
    check("t4_mode_total", o_cnt, 8'd4);

    // Saturation on a 2-bit counter, then clear colliding with a detection
    sel = 1; rl = 3; cmax = 3;
    do_reset();
    overlap = 1'b1; pol_sel = 2'b11;
    run("1111111");
    check("t5_sat_cnt", o_cnt, 8'd3);
    check("t5_sat_flag", {7'd0, o_sat}, 8'd1);
    step(1'b1, 1'b1, 1'b1);
    check("t5_clr_cnt", o_cnt, 8'd0);
    check("t5_clr_flag", {7'd0, o_sat}, 8'd0);
    run("1");

    // Length-5 runs of zeros, non-overlapping
    sel = 2; rl = 5; cmax = 255;
    do_reset();
    overlap = 1'b0; pol_sel = 2'b11;
    run("0000000000");
    check("t6_total", o_cnt, 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
